// File: rtl/tmfir_pkg.sv
// ============================================================================
// Module : tmfir_pkg
// Brief  : Shared types and constants for the time-multiplexed FIR sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tmfir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int MAX_PIPE = 7;
    localparam int DRAIN_W  = 3;
    localparam int LML_MIN  = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Select width shared with the SRL16E delayline: never narrower than 4.
    function automatic int lml_width(input int m);
        return (clog2(m) > LML_MIN) ? clog2(m) : LML_MIN;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tmfir_tap_counter.sv
// ============================================================================
// Module : tmfir_tap_counter
// Brief  : Modulo-M up-counter with start (count==0) and terminal-count flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tmfir_tap_counter #(
    parameter int M = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_start,
    output logic         o_tc
);

    localparam logic [W-1:0] c_last = W'(M - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_start = (r_count == '0);
    assign o_tc    = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/tmfir_sequencer.sv
// ============================================================================
// Module : tmfir_sequencer
// Brief  : Sample-accept / tap-walk / MAC-drain / result-hold control for one
//          time-multiplexed FIR channel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tmfir_sequencer
    import tmfir_pkg::*;
#(
    parameter int M    = 16,
    parameter int LML  = lml_width(M),
    parameter int PIPE = 2
) (
    input  logic           CLK,
    input  logic           RSTN,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           out_ready,
    output logic           out_valid,
    output logic           dl_en,
    output logic [LML-1:0] dl_sel,
    output logic [LML-1:0] coef_addr,
    output logic           mac_clr,
    output logic           mac_en,
    output logic           mac_last,
    input  logic           flush,
    output logic           primed,
    output logic           busy
);

    localparam int                 c_fill_w     = clog2(M + 1);
    localparam logic [c_fill_w-1:0] c_fill_max  = c_fill_w'(M);
    localparam logic [DRAIN_W-1:0]  c_drain_last = DRAIN_W'((PIPE > 0) ? PIPE - 1 : 0);

    state_t              r_state;
    state_t              w_next;
    logic [DRAIN_W-1:0]  r_drain;
    logic [c_fill_w-1:0] r_fill;
    logic [LML-1:0]      w_tap;
    logic                w_tap_start;
    logic                w_tap_tc;
    logic                w_accept;
    logic                w_run;

    assign w_run    = (r_state == RUN);
    assign w_accept = in_valid & (r_state == IDLE);

    // The counter itself is the registered select/address; it sits at 0 outside RUN.
    tmfir_tap_counter #(
        .M (M),
        .W (LML)
    ) u_tap (
        .clk     (CLK),
        .rst_n   (RSTN),
        .i_en    (w_run),
        .o_count (w_tap),
        .o_start (w_tap_start),
        .o_tc    (w_tap_tc)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (w_tap_tc) w_next = (PIPE == 0) ? HOLD : DRAIN;
            DRAIN:   if (r_drain == c_drain_last) w_next = HOLD;
            HOLD:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        dl_en     = (r_state == IDLE) & in_valid;
        mac_en    = w_run;
        mac_clr   = w_run & w_tap_start;
        mac_last  = w_run & w_tap_tc;
        out_valid = (r_state == HOLD);
        busy      = (r_state != IDLE);
        dl_sel    = w_tap;
        coef_addr = w_tap;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_drain <= '0;
        end else if (r_state == DRAIN) begin
            r_drain <= (r_drain == c_drain_last) ? '0 : r_drain + 1'b1;
        end else begin
            r_drain <= '0;
        end
    end

    // Flush wins over the old count but still credits a same-cycle acceptance.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_fill <= '0;
        end else if (flush) begin
            r_fill <= w_accept ? c_fill_w'(1) : '0;
        end else if (w_accept && (r_fill != c_fill_max)) begin
            r_fill <= r_fill + 1'b1;
        end
    end

    assign primed = (r_fill == c_fill_max);

endmodule

`default_nettype wire

// File: tb/tb_tmfir_sequencer.sv
// ============================================================================
// Module : tb_tmfir_sequencer
// Brief  : Randomized bench for tmfir_sequencer with an attached delayline/MAC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tmfir_sequencer;

    localparam int M     = 16;
    localparam int PIPE  = 2;
    localparam int LML   = 4;
    localparam int M2    = 20;
    localparam int PIPE2 = 0;
    localparam int LML2  = 5;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    logic           in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic           in_ready, out_valid, dl_en, mac_clr, mac_en, mac_last, primed, busy;
    logic [LML-1:0] dl_sel, coef_addr;

    logic            in_valid2 = 1'b0, out_ready2 = 1'b1, flush2 = 1'b0;
    logic            in_ready2, out_valid2, dl_en2, mac_clr2, mac_en2, mac_last2, primed2, busy2;
    logic [LML2-1:0] dl_sel2, coef_addr2;

    tmfir_sequencer #(.M(M), .LML(LML), .PIPE(PIPE)) dut (
        .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid), .dl_en(dl_en), .dl_sel(dl_sel),
        .coef_addr(coef_addr), .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last),
        .flush(flush), .primed(primed), .busy(busy)
    );

    tmfir_sequencer #(.M(M2), .LML(LML2), .PIPE(PIPE2)) dut20 (
        .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_ready(out_ready2), .out_valid(out_valid2), .dl_en(dl_en2), .dl_sel(dl_sel2),
        .coef_addr(coef_addr2), .mac_clr(mac_clr2), .mac_en(mac_en2), .mac_last(mac_last2),
        .flush(flush2), .primed(primed2), .busy(busy2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: d = cycles since acceptance (0 = idle), fill = priming count.
    int          d    = 0;
    int          fill = 0;
    int          hist[$];
    logic [7:0]  dl_mem[0:(1<<LML)-1];
    longint      acc  = 0;
    logic [7:0]  din  = 8'd0;

    function automatic longint ref_conv();
        longint s = 0;
        for (int k = 0; k < M; k++)
            if (hist.size() > k) s += longint'(k + 1) * longint'(hist[hist.size() - 1 - k]);
        return s;
    endfunction

    task automatic compare_outputs(input string tag);
        logic [7:0] act_ctrl, exp_ctrl;
        int         exp_sel;
        act_ctrl = {in_ready, out_valid, dl_en, mac_clr, mac_en, mac_last, busy, primed};
        exp_ctrl = {d == 0, d > M + PIPE, (d == 0) && in_valid, d == 1,
                    (d >= 1) && (d <= M), d == M, d != 0, fill == M};
        exp_sel  = ((d >= 1) && (d <= M)) ? d - 1 : 0;
        check({tag, "_ctrl"}, 32'(act_ctrl), 32'(exp_ctrl));
        check({tag, "_sel"},  32'(dl_sel), 32'(exp_sel));
        check({tag, "_addr"}, 32'(coef_addr), 32'(exp_sel));
    endtask

    task automatic step(input logic iv, input logic orr, input logic fl);
        logic accept;
        @(negedge CLK);
        in_valid  = iv;
        out_ready = orr;
        flush     = fl;
        din       = 8'($urandom_range(0, 255));
        #1;
        compare_outputs("cyc");
        accept = (d == 0) && iv;
        if (mac_en) begin
            longint prod = longint'(coef_addr + 1) * longint'(dl_mem[dl_sel]);
            acc = mac_clr ? prod : acc + prod;
        end
        if (dl_en) begin
            for (int i = (1 << LML) - 1; i > 0; i--) dl_mem[i] = dl_mem[i - 1];
            dl_mem[0] = din;
        end
        if ((d > M + PIPE) && orr)
            check("conv", 32'(acc), 32'(ref_conv()));
        if (accept) begin
            hist.push_back(int'(din));
            d = 1;
        end else if (d > 0) begin
            if (d <= M + PIPE) d++;
            else if (orr) d = 0;
        end
        if (fl) fill = accept ? 1 : 0;
        else if (accept && fill < M) fill++;
    endtask

    task automatic run_dut20();
        @(negedge CLK);
        in_valid2 = 1'b1;
        #1;
        check("m20_accept", 32'({dl_en2, in_ready2}), 32'(2'b11));
        for (int c = 1; c <= 23; c++) begin
            @(negedge CLK);
            in_valid2 = 1'b0;
            #1;
            check("m20_sel",  32'(dl_sel2), 32'((c <= M2) ? c - 1 : 0));
            check("m20_addr", 32'(coef_addr2), 32'((c <= M2) ? c - 1 : 0));
            check("m20_strb", 32'({mac_en2, mac_clr2, mac_last2, out_valid2, in_ready2}),
                  32'({c <= M2, c == 1, c == M2, c == M2 + 1, c > M2 + 1}));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << LML); i++) dl_mem[i] = 8'd0;
        repeat (2) @(negedge CLK);
        #1;
        compare_outputs("reset");
        @(negedge CLK);
        RSTN = 1'b1;

        run_dut20();

        // Back-to-back priming with the result port always ready.
        for (int i = 0; i < M * (M + PIPE + 2) + 4; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        // Flush coinciding with an acceptance.
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < M + PIPE + 4; i++) step(1'b0, 1'b1, 1'b0);

        // Backpressure in HOLD while a new sample is offered.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < M + PIPE + 10; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 499) == 0);

        // Abort a run at tap 5 with an asynchronous reset.
        for (int i = 0; i < 200 && d != 6; i++) step(1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        in_valid = 1'b0;
        RSTN     = 1'b0;
        d        = 0;
        fill     = 0;
        #1;
        compare_outputs("midrst");
        @(negedge CLK);
        #1;
        compare_outputs("inrst");
        RSTN = 1'b1;
        for (int i = 0; i < M + PIPE + 6; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
